// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM state type and default latencies for the HI/LO multiply/divide unit.
// MULDIV_MADD_EN enables the MADD/MSUB accumulate ops.
package muldiv_pkg;

  localparam int DEF_MUL_LAT = 5;
  localparam int DEF_DIV_LAT = 10;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // Multi-cycle ops that occupy the unit; MADD/MSUB only exist when enabled.
  function automatic logic is_long_op(input logic [2:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_long_op = 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MSUB:                   is_long_op = 1'b1;
`endif
      default:                            is_long_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_calc.sv
// Combinational 2*XLEN result {hi,lo} from the latched op/operands and current HI/LO.
// MADD/MSUB accumulate terms are built only with MULDIV_MADD_EN.
module muldiv_calc
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic [XLEN-1:0]   hi,
  input  logic [XLEN-1:0]   lo,
  output logic [2*XLEN-1:0] result
);

  logic            sgn, a_neg, b_neg, b_zero;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic [XLEN-1:0] a_mag, b_mag, q_mag, r_mag, q, r;

  always_comb begin
    sgn    = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    a_ext  = sgn ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    b_ext  = sgn ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    prod   = a_ext * b_ext;
    // Sign-magnitude divide: min/-1 falls out as |min| = 2^(XLEN-1) = min.
    a_neg  = (op == OP_DIV) && a[XLEN-1];
    b_neg  = (op == OP_DIV) && b[XLEN-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    b_zero = (b == '0);
    q_mag  = b_zero ? '1 : a_mag / b_mag;
    r_mag  = b_zero ? '0 : a_mag % b_mag;
    q      = (a_neg ^ b_neg) ? -q_mag : q_mag;
    r      = a_neg ? -r_mag : r_mag;
    case (op)
      OP_MULT, OP_MULTU: result = prod;
      OP_DIV, OP_DIVU:   result = b_zero ? {a, {XLEN{1'b1}}} : {r, q};
`ifdef MULDIV_MADD_EN
      OP_MADD:           result = {hi, lo} + prod;
      OP_MSUB:           result = {hi, lo} - prod;
`endif
      default:           result = {hi, lo};
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit: IDLE/RUN FSM, latency counter, HI/LO registers.
// MULDIV_MADD_EN enables MADD/MSUB; otherwise ops 6/7 are ignored.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [2*XLEN-1:0] result;
  logic              accept, mt_wr, finish;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_RUN;
      S_RUN:  if (flush || cnt == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    accept = (state == S_IDLE) && start && !flush && is_long_op(op);
    mt_wr  = (state == S_IDLE) && start && !flush && (op == OP_MTHI || op == OP_MTLO);
    finish = (state == S_RUN) && !flush && (cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      done <= 1'b0;
      hi   <= '0;
      lo   <= '0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
        cnt  <= is_div_op(op) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
      end else if (state == S_RUN) begin
        cnt <= (flush || cnt == '0) ? '0 : cnt - CNT_W'(1);
      end
      if (finish) {hi, lo} <= result;
      if (mt_wr) begin
        if (op == OP_MTHI) hi <= a;
        else               lo <= a;
      end
    end
  end

  assign busy = (state == S_RUN);

  // HI/LO cannot change while RUN, so the live registers serve as the accumulate base.
  muldiv_calc #(.XLEN(XLEN)) u_calc (
    .op(op_q), .a(a_q), .b(b_q), .hi(hi), .lo(lo), .result(result)
  );

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/HI/LO width.
REQ-002 SHALL have parameter MUL_LAT, default 5, multiply cycles from accepted start to result visible (>=1).
REQ-003 SHALL have parameter DIV_LAT, default 10, divide cycles from accepted start to result visible (>=1).
REQ-004 SHALL have clk  in  1  clock; reset  in  1  reset: reset reset, synchronous, active-high; clock clk.
REQ-005 SHALL have start  in  1  request to launch the op on op/a/b this cycle.
REQ-006 SHALL have op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
REQ-007 SHALL have a, b  in  XLEN each  operands (rs, rt values after bypass).
REQ-008 SHALL have flush  in  1  exception/eret kill of any in-flight op.
REQ-009 SHALL have busy  out  1  registered; high while an op is running.
REQ-010 SHALL have done  out  1  one-cycle pulse when HI/LO take a computed result.
REQ-011 SHALL have hi, lo  out  XLEN each  architectural HI/LO registers.

Function
REQ-012 SHALL implement FSM IDLE->RUN on accepted MULT/MULTU/DIV/DIVU/MADD/MSUB; RUN->IDLE when counter hits 0 or flush.
REQ-013 Start SHALL be accepted only in IDLE with flush low; start in RUN SHALL be ignored (no queueing).
REQ-014 On accept, a/b/op SHALL be latched; counter loaded with LAT-1; busy high from next cycle.
REQ-015 Result SHALL be written to hi/lo in the cycle counter reaches 0; hi/lo visible and busy low exactly LAT cycles after the accept edge; done high that same cycle.
REQ-016 MTHI/MTLO SHALL write a to hi/lo at next edge, no busy, no done, accepted only in IDLE.
REQ-017 MULT/MULTU: {hi,lo} = signed/unsigned 2*XLEN product of a,b.
REQ-018 DIV/DIVU: lo = quotient truncated toward zero, hi = remainder with sign of a.
REQ-019 Divide by zero: hi = a, lo = all ones; no trap.
REQ-020 Signed DIV of minimum value by -1: lo = minimum value, hi = 0.
REQ-021 MADD/MSUB: {hi,lo} = {hi,lo} +/- signed(a*b), modulo 2^(2*XLEN), using HI/LO value at accept.
REQ-022 flush in RUN SHALL abort: hi/lo unchanged, busy low next cycle, no done.
REQ-023 flush and start in same cycle: flush wins, start (including MTHI/MTLO) discarded.
REQ-024 flush in IDLE SHALL have no effect.

Reset
REQ-025 reset SHALL dominate flush and start; next edge: state IDLE, counter 0, busy 0, done 0, hi 0, lo 0.
REQ-026 reset mid-RUN SHALL discard the op with no hi/lo update.

Configuration
REQ-027 Macro MULDIV_MADD_EN defined: ops 6/7 behave per REQ-021.
REQ-028 MULDIV_MADD_EN undefined: ops 6/7 SHALL be treated as no-op (not accepted, busy stays low, hi/lo unchanged) and accumulate logic SHALL be absent.

Structure
REQ-029 Shared package muldiv_pkg SHALL hold op encoding constants, FSM state typedef, default latencies.
REQ-030 One sub-module muldiv_calc SHALL compute the combinational 2*XLEN result from latched op/a/b/hi/lo; muldiv_unit holds FSM, counter and HI/LO.

Verification
REQ-031 MULT a=0xFFFFFFFD b=7, default params -> busy 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB; done one pulse.
REQ-032 DIV a=0xFFFFFFF9 b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7 b=0 -> hi=7, lo=0xFFFFFFFF.
REQ-033 MULT 2*3 with hi=0xA, lo=0xB; flush 2 cycles after accept -> busy low next cycle, hi=0xA, lo=0xB, no done.
REQ-034 start MULTU during RUN of DIV -> ignored; only DIV result lands; MTLO a=0x55 same cycle as flush -> lo unchanged.
REQ-035 MULDIV_MADD_EN set: hi=0, lo=5, MADD a=3 b=4 -> hi=0, lo=0x11; unset: same stimulus -> busy stays 0, lo=5.
REQ-036 reset asserted mid-DIV -> next cycle busy=0, hi=0, lo=0, no done.
